// File: rtl/arch_state_checker_pkg.sv
// rtl/arch_state_checker_pkg.sv - shared types for the end-of-run architectural state checker
package arch_state_checker_pkg;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, CHECK, DONE} chk_state_t;

  // start and table writes are only honoured while no run is in flight
  function automatic logic is_accepting(chk_state_t s);
    return (s == IDLE) || (s == DONE);
  endfunction

endpackage

// File: rtl/arch_state_checker_sat_counter.sv
// rtl/arch_state_checker_sat_counter.sv - up-counter that sticks at all-ones, clear has priority
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    count <= '0;
    else if (clr)                  count <= '0;
    else if (inc && !(&count))     count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/arch_state_checker.sv
// rtl/arch_state_checker.sv - watches the retire stream for program end, then sweeps and
// checks the architectural register file against a loadable expected/mask table
module arch_state_checker
  import arch_state_checker_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int XLEN         = 32,
  parameter int TIMEOUT      = 500,
  parameter int QUIET_CYCLES = 16,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16,
  localparam int RW          = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             exp_we,
  input  logic [RW-1:0]    exp_idx,
  input  logic [XLEN-1:0]  exp_val,
  input  logic             exp_chk,
  input  logic             commit_valid,
  input  logic [RW-1:0]    commit_rd,
  input  logic             commit_wen,
  input  logic             halt,
  output logic [RW-1:0]    rf_raddr,
  input  logic [XLEN-1:0]  rf_rdata,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] err_count,
  output logic [RW-1:0]    fail_idx,
  output logic [XLEN-1:0]  fail_got,
  output logic [XLEN-1:0]  fail_exp,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] commit_count
);

  localparam int SW = RW + 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef struct packed {
    logic            chk;
    logic [XLEN-1:0] val;
  } exp_entry_t;

  chk_state_t      state_q, state_d;
  exp_entry_t      exp_tab [NUM_REGS];
  exp_entry_t      cur;
  logic [DW-1:0]   drain_cnt;
  logic [SW-1:0]   sweep_q;
  logic [RW-1:0]   cmp_idx;
  logic [CNT_W-1:0] quiet_count;
  logic            run_clr, in_run, in_check;
  logic            halt_hit, quiet_hit, to_hit, drain_last, sweep_last;
  logic            x0_guard, mismatch, timeout_q, x0_wr_q;
  logic [XLEN-1:0] exp_eff;
  logic            unused_x0;

  assign run_clr    = is_accepting(state_q) && start;
  assign halt_hit   = commit_valid && halt;
  assign quiet_hit  = !commit_valid && (commit_count != '0) &&
                      (quiet_count == CNT_W'(QUIET_CYCLES - 1));
  assign to_hit     = (TIMEOUT != 0) && (cycle_count == CNT_W'(TIMEOUT - 1));
  assign drain_last = (drain_cnt == DW'(DRAIN_CYCLES - 1));
  assign sweep_last = (sweep_q == SW'(NUM_REGS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start)                            state_d = RUN;
      RUN:        if (halt_hit || quiet_hit || to_hit)  state_d = DRAIN;
      DRAIN:      if (drain_last)                       state_d = CHECK;
      CHECK:      if (sweep_last)                       state_d = DONE;
      default:                                          state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    in_run   = 1'b0;
    in_check = 1'b0;
    rf_raddr = '0;
    case (state_q)
      RUN:   begin busy = 1'b1; in_run = 1'b1; end
      DRAIN: busy = 1'b1;
      CHECK: begin
        busy     = 1'b1;
        in_check = 1'b1;
        if (sweep_q < SW'(NUM_REGS)) rf_raddr = sweep_q[RW-1:0];
      end
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign pass    = done && (err_count == '0) && !timeout_q;
  assign timeout = timeout_q;

  sat_counter #(.CNT_W(CNT_W)) u_cycle (
    .clk(clk), .rst_n(reset), .clr(run_clr), .inc(in_run), .count(cycle_count));
  sat_counter #(.CNT_W(CNT_W)) u_commit (
    .clk(clk), .rst_n(reset), .clr(run_clr), .inc(in_run && commit_valid),
    .count(commit_count));
  sat_counter #(.CNT_W(CNT_W)) u_quiet (
    .clk(clk), .rst_n(reset), .clr(run_clr || (in_run && commit_valid)),
    .inc(in_run && !commit_valid && (commit_count != '0)), .count(quiet_count));
  sat_counter #(.CNT_W(CNT_W)) u_err (
    .clk(clk), .rst_n(reset), .clr(run_clr), .inc(mismatch), .count(err_count));

  // read data lags the address by one cycle, so compare entry sweep-1
  assign cmp_idx  = sweep_q[RW-1:0] - RW'(1);
  assign cur      = exp_tab[cmp_idx];
  assign x0_guard = (cmp_idx == '0) && (rf_rdata != '0);
  assign mismatch = in_check && (sweep_q != '0) &&
                    ((cur.chk && (rf_rdata != cur.val)) || x0_guard);
  assign exp_eff  = x0_guard ? '0 : cur.val;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drain_cnt <= '0;
      sweep_q   <= '0;
      timeout_q <= 1'b0;
      x0_wr_q   <= 1'b0;
      fail_idx  <= '0;
      fail_got  <= '0;
      fail_exp  <= '0;
    end else begin
      drain_cnt <= (state_q == DRAIN) ? drain_cnt + DW'(1) : '0;
      sweep_q   <= in_check ? sweep_q + SW'(1) : '0;
      if (run_clr) begin
        timeout_q <= 1'b0;
        x0_wr_q   <= 1'b0;
        fail_idx  <= '0;
        fail_got  <= '0;
        fail_exp  <= '0;
      end else begin
        if (in_run && to_hit && !halt_hit && !quiet_hit) timeout_q <= 1'b1;
        if (in_run && commit_valid && commit_wen && (commit_rd == '0)) x0_wr_q <= 1'b1;
        if (mismatch && (err_count == '0)) begin
          fail_idx <= cmp_idx;
          fail_got <= rf_rdata;
          fail_exp <= exp_eff;
        end
      end
    end
  end

  // x0 writes are tracked but never flagged; the sweep's x0==0 check is the real guard
  assign unused_x0 = x0_wr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) exp_tab[i] <= '0;
    end else if (is_accepting(state_q) && exp_we) begin
      exp_tab[exp_idx] <= {exp_chk, exp_val};
    end
  end

endmodule
